// File: rtl/battle_damage_fsm.sv
// ============================================================================
// Module   : battle_damage_fsm
// Purpose  : Turn resolution for the battle datapath. Accepts an attack,
//            waits a fixed decorrelation delay, samples the random nibble,
//            decides hit/miss/critical and applies saturating damage to the
//            target's HP. Reports fainting and game-over.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module battle_damage_fsm #(
  parameter int HP_W        = 4,
  parameter int HP_INIT     = 9,
  parameter int DMG_W       = 4,
  parameter int HIT_THRESH  = 8,
  parameter int CRIT_VAL    = 15,
  parameter int SAMPLE_WAIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             attacker,
  input  logic [DMG_W-1:0] dmg,
  input  logic [3:0]       rnd,
  input  logic             new_game,
  output logic [HP_W-1:0]  hp_p,
  output logic [HP_W-1:0]  hp_e,
  output logic [3:0]       last_rnd,
  output logic             hit,
  output logic             crit,
  output logic             busy,
  output logic             done,
  output logic             faint_p,
  output logic             faint_e,
  output logic             game_over
);

  // Counter must hold SAMPLE_WAIT-1; keep at least one bit for SAMPLE_WAIT=1.
  localparam int CNT_W = (SAMPLE_WAIT > 1) ? $clog2(SAMPLE_WAIT) : 1;
  // Common width for comparing HP against doubled damage without overflow.
  localparam int CMP_W = (HP_W > DMG_W + 1) ? HP_W : DMG_W + 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SAMPLE_WAIT - 1);
  localparam logic [HP_W-1:0]  HP_RELOAD = HP_W'(HP_INIT);
  localparam logic [3:0]       THRESH_4  = 4'(HIT_THRESH);
  localparam logic [3:0]       CRIT_4    = 4'(CRIT_VAL);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_RESOLVE = 3'd2,
    S_DONE    = 3'd3,
    S_OVER    = 3'd4
  } state_t;

  state_t             r_state;
  logic               r_attacker;
  logic [DMG_W-1:0]   r_dmg;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_hit_n;
  logic               w_crit_n;
  logic [DMG_W:0]     w_eff;
  logic [HP_W-1:0]    w_tgt_hp;
  logic [CMP_W-1:0]   w_hp_x;
  logic [CMP_W-1:0]   w_eff_x;
  logic [HP_W-1:0]    w_new_hp;

  // Hit/crit decision and saturating damage on the attack's target.
  always_comb begin
    w_hit_n  = (last_rnd >= THRESH_4);
    w_crit_n = w_hit_n && (last_rnd == CRIT_4);
    w_eff    = w_crit_n ? {r_dmg, 1'b0} : {1'b0, r_dmg};
    w_tgt_hp = r_attacker ? hp_p : hp_e;
    w_hp_x   = CMP_W'(w_tgt_hp);
    w_eff_x  = CMP_W'(w_eff);
    w_new_hp = (w_hp_x > w_eff_x) ? HP_W'(w_hp_x - w_eff_x) : '0;
  end

  // Status flags decoded from the state and HP registers.
  always_comb begin
    busy      = (r_state == S_WAIT) || (r_state == S_RESOLVE) || (r_state == S_DONE);
    game_over = (r_state == S_OVER);
    faint_p   = (hp_p == '0);
    faint_e   = (hp_e == '0);
  end

  // Turn sequencer: owns HP registers and all registered result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_attacker <= 1'b0;
      r_dmg      <= '0;
      r_cnt      <= '0;
      hp_p       <= HP_RELOAD;
      hp_e       <= HP_RELOAD;
      last_rnd   <= 4'd0;
      hit        <= 1'b0;
      crit       <= 1'b0;
      done       <= 1'b0;
    end else if (new_game) begin
      // Restart wins over any start and over an in-flight attack.
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      hp_p     <= HP_RELOAD;
      hp_e     <= HP_RELOAD;
      last_rnd <= 4'd0;
      hit      <= 1'b0;
      crit     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_attacker <= attacker;
            r_dmg      <= dmg;
            r_cnt      <= '0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            last_rnd <= rnd;
            r_state  <= S_RESOLVE;
          end
        end
        S_RESOLVE: begin
          hit  <= w_hit_n;
          crit <= w_crit_n;
          if (w_hit_n) begin
            if (r_attacker) begin
              hp_p <= w_new_hp;
            end else begin
              hp_e <= w_new_hp;
            end
          end
          done    <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          if ((hp_p == '0) || (hp_e == '0)) begin
            r_state <= S_OVER;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_OVER: begin
          r_state <= S_OVER;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_battle_damage_fsm.sv
// ============================================================================
// Module   : tb_battle_damage_fsm
// Purpose  : Directed self-checking bench for battle_damage_fsm.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_battle_damage_fsm;

  localparam int LAT = 5;  // edges from the start edge until done is seen

  logic       clk;
  logic       reset;
  logic       start;
  logic       attacker;
  logic [3:0] dmg;
  logic [3:0] rnd;
  logic       new_game;
  logic [3:0] hp_p;
  logic [3:0] hp_e;
  logic [3:0] last_rnd;
  logic       hit;
  logic       crit;
  logic       busy;
  logic       done;
  logic       faint_p;
  logic       faint_e;
  logic       game_over;

  int checks;
  int errors;

  battle_damage_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .attacker  (attacker),
    .dmg       (dmg),
    .rnd       (rnd),
    .new_game  (new_game),
    .hp_p      (hp_p),
    .hp_e      (hp_e),
    .last_rnd  (last_rnd),
    .hit       (hit),
    .crit      (crit),
    .busy      (busy),
    .done      (done),
    .faint_p   (faint_p),
    .faint_e   (faint_e),
    .game_over (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge, then settle 1 time unit.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one attack and wait (bounded) for done; lat = edges after start edge.
  task automatic run_attack(input logic att, input logic [3:0] d,
                            input logic [3:0] r, output int lat);
    rnd      = r;
    attacker = att;
    dmg      = d;
    start    = 1'b1;
    tick();
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic do_new_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #23;
    reset = 1'b1;
    tick();
    checks++; if (hp_p !== 4'd9) begin errors++; $display("FAIL reset_hp_p got %0d want 9", hp_p); end
    checks++; if (hp_e !== 4'd9) begin errors++; $display("FAIL reset_hp_e got %0d want 9", hp_e); end
    checks++; if ({hit, crit, done, busy, game_over} !== 5'b0) begin errors++;
      $display("FAIL reset_flags got %b want 00000", {hit, crit, done, busy, game_over}); end
    checks++; if (last_rnd !== 4'd0) begin errors++; $display("FAIL reset_last_rnd got %0d want 0", last_rnd); end
    checks++; if ({faint_p, faint_e} !== 2'b00) begin errors++; $display("FAIL reset_faint got %b want 00", {faint_p, faint_e}); end
  endtask

  task automatic test_hit();
    int lat;
    run_attack(1'b0, 4'd3, 4'd10, lat);
    checks++; if (lat != LAT) begin errors++; $display("FAIL hit_latency got %0d want %0d", lat, LAT); end
    checks++; if ({hit, crit} !== 2'b10) begin errors++; $display("FAIL hit_flags got %b want 10", {hit, crit}); end
    checks++; if (hp_e !== 4'd6 || hp_p !== 4'd9) begin errors++;
      $display("FAIL hit_hp got p=%0d e=%0d want p=9 e=6", hp_p, hp_e); end
    checks++; if (last_rnd !== 4'd10) begin errors++; $display("FAIL hit_last_rnd got %0d want 10", last_rnd); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hit_busy_in_done got %b want 1", busy); end
    tick();
    checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL hit_back_idle got %b want 00", {done, busy}); end
  endtask

  task automatic test_miss();
    int lat;
    int dcnt;
    run_attack(1'b1, 4'd3, 4'd5, lat);
    checks++; if (lat != LAT) begin errors++; $display("FAIL miss_latency got %0d want %0d", lat, LAT); end
    checks++; if (hit !== 1'b0 || hp_p !== 4'd9 || hp_e !== 4'd6) begin errors++;
      $display("FAIL miss_result got hit=%b p=%0d e=%0d want hit=0 p=9 e=6", hit, hp_p, hp_e); end
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) dcnt++;
    end
    checks++; if (dcnt != 0 || hit !== 1'b0) begin errors++;
      $display("FAIL miss_after got extra_done=%0d hit=%b want 0 0", dcnt, hit); end
  endtask

  task automatic test_crit_over();
    int lat;
    do_new_game();
    run_attack(1'b0, 4'd3, 4'd15, lat);
    checks++; if ({hit, crit} !== 2'b11 || hp_e !== 4'd3) begin errors++;
      $display("FAIL crit1 got hit/crit=%b e=%0d want 11 e=3", {hit, crit}, hp_e); end
    tick();
    run_attack(1'b0, 4'd3, 4'd15, lat);
    checks++; if (hp_e !== 4'd0 || faint_e !== 1'b1 || hp_p !== 4'd9) begin errors++;
      $display("FAIL crit2 got e=%0d faint_e=%b p=%0d want 0 1 9", hp_e, faint_e, hp_p); end
    tick();
    checks++; if (game_over !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL over_state got go=%b busy=%b want 1 0", game_over, busy); end
    attacker = 1'b1;
    dmg      = 4'd5;
    rnd      = 4'd12;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checks++; if (hp_p !== 4'd9 || hp_e !== 4'd0 || last_rnd !== 4'd15 || {hit, crit, done, busy, game_over} !== 5'b11001) begin
      errors++;
      $display("FAIL over_ignore_start got p=%0d e=%0d rnd=%0d flags=%b want 9 0 15 11001",
               hp_p, hp_e, last_rnd, {hit, crit, done, busy, game_over});
    end
  endtask

  task automatic test_rnd_change();
    int dcnt;
    do_new_game();
    rnd      = 4'd15;
    attacker = 1'b0;
    dmg      = 4'd3;
    start    = 1'b1;
    tick();                       // start edge N
    start = 1'b0;
    dcnt  = 0;
    tick();                       // N+1
    if (done) dcnt++;
    attacker = 1'b1;
    dmg      = 4'd7;
    start    = 1'b1;              // dropped: already busy
    tick();                       // N+2
    if (done) dcnt++;
    start = 1'b0;
    tick();                       // N+3
    if (done) dcnt++;
    rnd = 4'd2;
    tick();                       // N+4: sampling edge
    if (done) dcnt++;
    rnd = 4'd15;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (done) dcnt++;
    end
    checks++; if (last_rnd !== 4'd2 || hit !== 1'b0) begin errors++;
      $display("FAIL rnd_sample got last_rnd=%0d hit=%b want 2 0", last_rnd, hit); end
    checks++; if (dcnt != 1) begin errors++; $display("FAIL busy_start_drop got done_pulses=%0d want 1", dcnt); end
    checks++; if (hp_p !== 4'd9 || hp_e !== 4'd9 || busy !== 1'b0) begin errors++;
      $display("FAIL rnd_change_hp got p=%0d e=%0d busy=%b want 9 9 0", hp_p, hp_e, busy); end
  endtask

  task automatic test_new_game_abort();
    int lat;
    int dcnt;
    run_attack(1'b0, 4'd3, 4'd10, lat);
    checks++; if (hp_e !== 4'd6) begin errors++; $display("FAIL pre_abort_hp_e got %0d want 6", hp_e); end
    tick();
    attacker = 1'b0;
    dmg      = 4'd3;
    rnd      = 4'd10;
    start    = 1'b1;
    tick();                       // now in WAIT
    new_game = 1'b1;
    start    = 1'b1;
    tick();
    new_game = 1'b0;
    start    = 1'b0;
    checks++; if (busy !== 1'b0 || hp_e !== 4'd9 || hp_p !== 4'd9 || hit !== 1'b0 || last_rnd !== 4'd0) begin
      errors++;
      $display("FAIL abort_state got busy=%b p=%0d e=%0d hit=%b rnd=%0d want 0 9 9 0 0",
               busy, hp_p, hp_e, hit, last_rnd);
    end
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done || busy) dcnt++;
    end
    checks++; if (dcnt != 0) begin errors++; $display("FAIL abort_no_done got activity=%0d want 0", dcnt); end
  endtask

  task automatic test_async_reset();
    int lat;
    run_attack(1'b0, 4'd1, 4'd10, lat);
    checks++; if (hp_e !== 4'd8 || hit !== 1'b1) begin errors++;
      $display("FAIL pre_reset got e=%0d hit=%b want 8 1", hp_e, hit); end
    tick();
    attacker = 1'b0;
    dmg      = 4'd2;
    rnd      = 4'd15;
    start    = 1'b1;
    tick();                       // N
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();   // N+4: in RESOLVE
    #1;
    reset = 1'b0;
    #1;
    checks++; if (hp_e !== 4'd9 || hp_p !== 4'd9 || last_rnd !== 4'd0 || {hit, crit, done, busy, game_over} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset got p=%0d e=%0d rnd=%0d flags=%b want 9 9 0 00000",
               hp_p, hp_e, last_rnd, {hit, crit, done, busy, game_over});
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    run_attack(1'b1, 4'd4, 4'd10, lat);
    checks++; if (lat != LAT || hp_p !== 4'd5 || hp_e !== 4'd9) begin errors++;
      $display("FAIL post_reset got lat=%0d p=%0d e=%0d want %0d 5 9", lat, hp_p, hp_e, LAT); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b0;
    start    = 1'b0;
    attacker = 1'b0;
    dmg      = 4'd0;
    rnd      = 4'd0;
    new_game = 1'b0;
    test_reset();
    test_hit();
    test_miss();
    test_crit_over();
    test_rnd_change();
    test_new_game_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/battle_damage_fsm.md
Name: battle_damage_fsm

Overview:
Turn-resolution stage downstream of the 4-bit ring-oscillator random source in the battle datapath. It accepts a debounced attack request, waits a fixed decorrelation delay, then samples the random nibble. It decides hit, miss or critical, subtracts damage from the target's HP with saturation, and reports fainting and game-over. It owns both combatants' HP registers, which drive the HEX displays and LEDs.

Parameters:
HP_W, 4, width of each HP register
HP_INIT, 9, HP loaded at reset and on new_game (must fit HP_W)
DMG_W, 4, width of the damage input
HIT_THRESH, 8, hit when sampled rnd >= HIT_THRESH
CRIT_VAL, 15, critical when hit and rnd == CRIT_VAL
SAMPLE_WAIT, 4, cycles between accepting start and sampling rnd (>= 1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  attack request, single-cycle pulse, already debounced and edge-detected
attacker  in  1  0 = player attacks enemy, 1 = enemy attacks player; sampled with start
dmg  in  DMG_W  base damage; sampled with start
rnd  in  4  random nibble, already synchronised to clk
new_game  in  1  synchronous restart pulse
hp_p  out  HP_W  player HP
hp_e  out  HP_W  enemy HP
last_rnd  out  4  rnd value captured for the latest attack
hit  out  1  latest attack hit
crit  out  1  latest attack was critical
busy  out  1  high in WAIT, RESOLVE, DONE
done  out  1  one-cycle pulse when an attack completes
faint_p  out  1  hp_p == 0
faint_e  out  1  hp_e == 0
game_over  out  1  high in state OVER

Behaviour:
- Reset (reset low, async):
  - state = IDLE; hp_p = hp_e = HP_INIT.
  - last_rnd = 0; hit = crit = done = 0; internal counter = 0.
- States: IDLE, WAIT, RESOLVE, DONE, OVER.
- IDLE:
  - start = 1 at edge N: latch attacker and dmg, clear cnt, go to WAIT.
  - start = 0: stay.
- WAIT:
  - cnt increments each edge.
  - At the edge where cnt == SAMPLE_WAIT-1 (edge N+SAMPLE_WAIT): last_rnd <= rnd, go to RESOLVE.
- RESOLVE (one cycle):
  - hit_n = (last_rnd >= HIT_THRESH); crit_n = hit_n && (last_rnd == CRIT_VAL).
  - eff = crit_n ? 2*dmg : dmg, computed at DMG_W+1 bits with no overflow.
  - If hit_n: target HP <= (HP > eff) ? HP - eff : 0. Target is hp_e when attacker = 0, hp_p when attacker = 1.
  - On a miss, HP is unchanged.
  - hit <= hit_n, crit <= crit_n; go to DONE at edge N+SAMPLE_WAIT+1.
- DONE:
  - done = 1 for exactly this cycle; the HP update is already visible.
  - Next edge: go to OVER if hp_p == 0 or hp_e == 0, else IDLE.
- OVER:
  - start is ignored; game_over = 1.
  - Exit only via new_game or reset.
- Latency: start at edge N gives done high in the cycle after edge N+SAMPLE_WAIT+1 (SAMPLE_WAIT+2 cycles).
- start while busy or in OVER: dropped. It is not queued, and the latched attacker/dmg are unchanged.
- new_game (any state, sync):
  - HP reloads to HP_INIT; hit, crit, last_rnd cleared; cnt cleared; go to IDLE.
  - Has priority over start and over any in-flight attack; no done pulse for an aborted attack.
- dmg = 0 with a hit: hit = 1, HP unchanged.
- Both HP are never zero together; only the target changes per attack.
- hit and crit hold their values until the next RESOLVE or new_game.
- faint_p and faint_e are combinational compares on the HP registers.
- Async reset asserted mid-operation aborts the attack immediately, with all registers at their reset values.
- rnd is read only at the WAIT exit edge; changes on rnd at any other time have no effect.

Test Plan:
- Reset, then start with attacker = 0, dmg = 3, rnd held at 10 -> done 6 cycles after start; hit = 1, crit = 0; hp_e = 6; hp_p = 9; last_rnd = 10.
- start with attacker = 1, dmg = 3, rnd = 5 -> hit = 0; hp_p = 9; done pulses once; hit stays 0 afterwards.
- rnd = 15, dmg = 3, attacker = 0, hp_e = 9 -> crit = 1, eff = 6, hp_e = 3. A second crit then gives hp_e = 0 (saturated), faint_e = 1, OVER with game_over = 1; a further start leaves all outputs unchanged.
- Change rnd from 15 to 2 one cycle before the sampling edge, then back to 15 one cycle after it -> last_rnd = 2, miss. Assert start again while busy -> ignored, exactly one done.
- new_game asserted in the WAIT cycle of an attack (same cycle as a start) -> IDLE; HP = 9; no done pulse; the start is dropped.
- Async reset pulsed low while in RESOLVE -> all outputs return to reset values with no clock edge; normal operation resumes after release.
